decode_top: RTL and testbench
=============================

DECODE_TOP -- requirements
Module: decode_top

Interface
REQ-001 Parameters: none; all widths SHALL come from shared soc constants (PC_WIDTH=32, INSTR_WIDTH=32, REG_FILE_NUM=32, REG_WIDTH=32).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  system clock.
REQ-004 reset  in  1  async active-high reset.
REQ-005 fetch_instr_valid  in  1  instruction from fetch is valid.
REQ-006 fetch_instr_data  in  32  raw instruction word.
REQ-007 fetch_instr_pc  in  32  PC of that instruction.
REQ-008 stall_fetch  out  1  tells fetch to hold; fetch re-presents the same instruction.
REQ-009 stall_decode  in  1  downstream (ALU stage) cannot accept.
REQ-010 flush_decode  in  1  taken branch resolved downstream; kill younger work.
REQ-011 wb_valid / wb_dest / wb_data  in  1/5/32  register-file write port from writeback.
REQ-012 alu_req_valid  out  1  decoded request valid.
REQ-013 alu_req_info  out  decode_req_t  opcode, rd, ra_data, rb_data, imm (sign-extended 32), pc, writes_rd.
REQ-014 xcpt_decode  out  decode_xcpt_t  {valid, cause=ILLEGAL_INSTR, pc}.

Function
REQ-015 Encoding SHALL be opcode[31:25], rd[24:20], ra[19:15], rb[14:10], imm15[14:0].
REQ-016 Legal opcodes: ADD 0x00, SUB 0x01, MUL 0x02, ADDI 0x03, LDW 0x11, STW 0x13, BEQ 0x30, JUMP 0x31, NOP 0x7F; any other SHALL be illegal.
REQ-017 Reads: ADD/SUB/MUL/BEQ/STW read ra and rb; ADDI/LDW/JUMP read ra only; writes_rd=1 for ADD/SUB/MUL/ADDI/LDW with rd!=0.
REQ-018 Register r0 SHALL read 0, ignore writes and never cause a hazard.
REQ-019 Scoreboard: one pending bit per register; set when an instruction with writes_rd is accepted into the output register; cleared when wb_valid with matching wb_dest.
REQ-020 hazard = fetch_instr_valid and any read source pending, or writes_rd and rd already pending (WAW).
REQ-021 stall_fetch SHALL be combinational: stall_decode | hazard.
REQ-022 Accept when fetch_instr_valid & !hazard & !stall_decode & !flush_decode; output register loads next edge (latency 1 cycle).
REQ-023 Cycle with fetch_instr_valid & hazard & !stall_decode: alu_req_valid SHALL be 0 next cycle (bubble).
REQ-024 While stall_decode=1, alu_req_valid/alu_req_info/xcpt_decode SHALL hold their values.
REQ-025 flush_decode SHALL clear alu_req_valid next cycle regardless of stall_decode, and release the pending bit set by the killed held instruction; incoming instruction is dropped.
REQ-026 Simultaneous wb clear and new set on the same register: set SHALL win.
REQ-027 Illegal opcode: xcpt_decode.valid=1 with alu_req_valid=0 next cycle; no scoreboard set.
REQ-028 Register reads SHALL occur in the accept cycle; writes take effect at the clock edge.

Reset
REQ-029 Reset SHALL clear alu_req_valid, xcpt_decode.valid and all scoreboard bits, and zero the register file; alu_req_info resets to 0.
REQ-030 Reset asserted mid-stall SHALL discard the held request; stall_fetch follows its combinational definition.

Configuration
REQ-031 Macro DECODE_WB_BYPASS_EN: when defined, a source whose wb_valid/wb_dest matches in the same cycle SHALL not be a hazard and wb_data SHALL be forwarded; when undefined, that source stays a hazard that cycle (one extra stall cycle).

Structure
REQ-032 decode_req_t, decode_xcpt_t, opcode constants and register-index widths SHALL live in the shared core package.
REQ-033 Sub-module regfile: 32x32, two async read ports, one sync write port, r0 hardwired zero.

Verification
REQ-034 ADD r3,r1,r2 with r1=5, r2=7 preloaded -> next cycle alu_req_valid=1, ra_data=5, rb_data=7, rd=3.
REQ-035 ADD r3,... then SUB r4,r3,r1 back-to-back -> stall_fetch=1 until wb r3; SUB issues the cycle after wb (same cycle with DECODE_WB_BYPASS_EN, forwarded data).
REQ-036 opcode 0x55 at pc 0x1000 -> xcpt_decode={1,ILLEGAL_INSTR,0x1000}, alu_req_valid=0, scoreboard unchanged.
REQ-037 stall_decode held 3 cycles with valid ADDI r5 in output -> outputs stable; flush_decode then -> alu_req_valid=0, r5 pending cleared.
REQ-038 ADD r0,r1,r2 followed by ADD r6,r0,r0 -> no stall, ra_data=rb_data=0.

Source files
------------

// File: rtl/decode_top_pkg.sv
// -----------------------------------------------------------------------------
// decode_top_pkg
// Shared core constants and types for the decode stage.
//   - SoC widths (PC, instruction, register file geometry)
//   - opcode encodings and instruction field positions
//   - decode_req_t  : request handed to the ALU stage
//   - decode_xcpt_t : decode exception report
//   - classify()    : per-opcode legality / operand-usage lookup
// -----------------------------------------------------------------------------
package decode_top_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int INSTR_WIDTH  = 32;
    localparam int REG_FILE_NUM = 32;
    localparam int REG_WIDTH    = 32;

    localparam int REG_IDX_W    = $clog2(REG_FILE_NUM);
    localparam int OPCODE_W     = 7;
    localparam int IMM_W        = 15;

    // Instruction field positions: opcode[31:25] rd[24:20] ra[19:15] rb[14:10] imm15[14:0]
    localparam int OPCODE_LSB   = 25;
    localparam int RD_LSB       = 20;
    localparam int RA_LSB       = 15;
    localparam int RB_LSB       = 10;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 7'h00,
        OP_SUB  = 7'h01,
        OP_MUL  = 7'h02,
        OP_ADDI = 7'h03,
        OP_LDW  = 7'h11,
        OP_STW  = 7'h13,
        OP_BEQ  = 7'h30,
        OP_JUMP = 7'h31,
        OP_NOP  = 7'h7F
    } opcode_e;

    typedef enum logic [1:0] {
        XCPT_NONE     = 2'd0,
        ILLEGAL_INSTR = 2'd1
    } xcpt_cause_e;

    typedef struct packed {
        opcode_e                opcode;
        logic [REG_IDX_W-1:0]   rd;
        logic [REG_WIDTH-1:0]   ra_data;
        logic [REG_WIDTH-1:0]   rb_data;
        logic [REG_WIDTH-1:0]   imm;
        logic [PC_WIDTH-1:0]    pc;
        logic                   writes_rd;
    } decode_req_t;

    typedef struct packed {
        logic                   valid;
        xcpt_cause_e            cause;
        logic [PC_WIDTH-1:0]    pc;
    } decode_xcpt_t;

    typedef struct packed {
        logic legal;
        logic reads_ra;
        logic reads_rb;
        logic writes_rd;
    } op_class_t;

    // Operand usage per opcode. A destination of r0 never counts as a write,
    // so it can neither set a pending bit nor create a WAW hazard.
    function automatic op_class_t classify(input logic [OPCODE_W-1:0]  op,
                                           input logic [REG_IDX_W-1:0] rd);
        op_class_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: begin
                c.legal     = 1'b1;
                c.reads_ra  = 1'b1;
                c.reads_rb  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OP_ADDI, OP_LDW: begin
                c.legal     = 1'b1;
                c.reads_ra  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OP_STW, OP_BEQ: begin
                c.legal     = 1'b1;
                c.reads_ra  = 1'b1;
                c.reads_rb  = 1'b1;
            end
            OP_JUMP: begin
                c.legal     = 1'b1;
                c.reads_ra  = 1'b1;
            end
            OP_NOP: begin
                c.legal     = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        if (rd == '0) begin
            c.writes_rd = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/decode_top_regfile.sv
// -----------------------------------------------------------------------------
// decode_top_regfile
// 32 x 32 register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero. All registers clear on reset.
//   clock, reset                  : clock / async active-high reset
//   i_wr_en, i_wr_addr, i_wr_data : write port (effective at the clock edge)
//   i_rd_addr_a / o_rd_data_a     : read port A
//   i_rd_addr_b / o_rd_data_b     : read port B
// -----------------------------------------------------------------------------
module decode_top_regfile
    import decode_top_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [REG_IDX_W-1:0] i_wr_addr,
    input  logic [REG_WIDTH-1:0] i_wr_data,
    input  logic [REG_IDX_W-1:0] i_rd_addr_a,
    output logic [REG_WIDTH-1:0] o_rd_data_a,
    input  logic [REG_IDX_W-1:0] i_rd_addr_b,
    output logic [REG_WIDTH-1:0] o_rd_data_b
);

    logic [REG_WIDTH-1:0] w_regs [REG_FILE_NUM];

    assign w_regs[0] = '0;

    // Register zero has no storage; the others each own a word.
    genvar gi;
    generate
        for (gi = 1; gi < REG_FILE_NUM; gi++) begin : g_reg
            logic [REG_WIDTH-1:0] r_word;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_word <= '0;
                end else if (i_wr_en && (i_wr_addr == REG_IDX_W'(gi))) begin
                    r_word <= i_wr_data;
                end
            end

            assign w_regs[gi] = r_word;
        end
    endgenerate

    assign o_rd_data_a = w_regs[i_rd_addr_a];
    assign o_rd_data_b = w_regs[i_rd_addr_b];

endmodule

// File: rtl/decode_top.sv
// -----------------------------------------------------------------------------
// decode_top
// Decode stage: decodes one instruction per cycle from fetch, reads operands,
// tracks outstanding register writes with a per-register pending scoreboard,
// stalls fetch on RAW/WAW hazards or downstream back-pressure, and raises an
// exception for illegal opcodes.
//
// Ports
//   clock, reset                    : clock / async active-high reset
//   fetch_instr_valid/_data/_pc     : instruction from fetch
//   stall_fetch                     : combinational hold request to fetch
//   stall_decode                    : ALU stage cannot accept; hold outputs
//   flush_decode                    : kill held request and incoming instr
//   wb_valid, wb_dest, wb_data      : register-file write from writeback
//   alu_req_valid, alu_req_info     : registered decoded request (latency 1)
//   xcpt_decode                     : registered illegal-instruction report
//
// Configuration
//   DECODE_WB_BYPASS_EN : when defined, a source register written back in the
//   same cycle is forwarded from wb_data instead of stalling one more cycle.
// -----------------------------------------------------------------------------
module decode_top
    import decode_top_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_instr_valid,
    input  logic [INSTR_WIDTH-1:0] fetch_instr_data,
    input  logic [PC_WIDTH-1:0]    fetch_instr_pc,
    output logic                   stall_fetch,
    input  logic                   stall_decode,
    input  logic                   flush_decode,
    input  logic                   wb_valid,
    input  logic [REG_IDX_W-1:0]   wb_dest,
    input  logic [REG_WIDTH-1:0]   wb_data,
    output logic                   alu_req_valid,
    output decode_req_t            alu_req_info,
    output decode_xcpt_t           xcpt_decode
);

    // ---------------------------------------------------------------- fields
    logic [OPCODE_W-1:0]  w_op;
    logic [REG_IDX_W-1:0] w_rd;
    logic [REG_IDX_W-1:0] w_ra;
    logic [REG_IDX_W-1:0] w_rb;
    op_class_t            w_cls;

    assign w_op  = fetch_instr_data[OPCODE_LSB +: OPCODE_W];
    assign w_rd  = fetch_instr_data[RD_LSB     +: REG_IDX_W];
    assign w_ra  = fetch_instr_data[RA_LSB     +: REG_IDX_W];
    assign w_rb  = fetch_instr_data[RB_LSB     +: REG_IDX_W];
    assign w_cls = classify(w_op, w_rd);

    // -------------------------------------------------------- register file
    logic [REG_WIDTH-1:0] w_rf_a;
    logic [REG_WIDTH-1:0] w_rf_b;

    decode_top_regfile u_regfile (
        .clock       (clock),
        .reset       (reset),
        .i_wr_en     (wb_valid),
        .i_wr_addr   (wb_dest),
        .i_wr_data   (wb_data),
        .i_rd_addr_a (w_ra),
        .o_rd_data_a (w_rf_a),
        .i_rd_addr_b (w_rb),
        .o_rd_data_b (w_rf_b)
    );

    // ------------------------------------------------------------ forwarding
    logic w_fwd_a;
    logic w_fwd_b;

`ifdef DECODE_WB_BYPASS_EN
    assign w_fwd_a = wb_valid && (wb_dest == w_ra) && (w_ra != '0);
    assign w_fwd_b = wb_valid && (wb_dest == w_rb) && (w_rb != '0);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    logic [REG_WIDTH-1:0] w_ra_data;
    logic [REG_WIDTH-1:0] w_rb_data;

    // Unused operands are presented as zero so the request is deterministic.
    assign w_ra_data = !w_cls.reads_ra ? '0 : (w_fwd_a ? wb_data : w_rf_a);
    assign w_rb_data = !w_cls.reads_rb ? '0 : (w_fwd_b ? wb_data : w_rf_b);

    // ------------------------------------------------------ hazard detection
    logic [REG_FILE_NUM-1:0] r_pending;
    logic [REG_FILE_NUM-1:0] w_pending_next;
    logic w_busy_a;
    logic w_busy_b;
    logic w_waw;
    logic w_hazard;
    logic w_accept;

    // r_pending[0] is held at zero, so r0 sources never look busy.
    assign w_busy_a = w_cls.reads_ra && r_pending[w_ra] && !w_fwd_a;
    assign w_busy_b = w_cls.reads_rb && r_pending[w_rb] && !w_fwd_b;
    // A destination freed in the same cycle is still a WAW hazard: the
    // scoreboard bit only drops at the edge.
    assign w_waw    = w_cls.writes_rd && r_pending[w_rd];
    assign w_hazard = fetch_instr_valid && (w_busy_a || w_busy_b || w_waw);

    assign stall_fetch = stall_decode || w_hazard;
    assign w_accept    = fetch_instr_valid && !w_hazard && !stall_decode && !flush_decode;

    // ------------------------------------------------------------ scoreboard
    decode_req_t  r_req_info;
    logic         r_req_valid;
    decode_xcpt_t r_xcpt;

    // Clears are applied before the set so that a writeback and a new
    // writer targeting the same register leave the bit set.
    always_comb begin
        w_pending_next = r_pending;
        if (wb_valid) begin
            w_pending_next[wb_dest] = 1'b0;
        end
        // A flushed request never reaches writeback, so give its register back.
        if (flush_decode && r_req_valid && r_req_info.writes_rd) begin
            w_pending_next[r_req_info.rd] = 1'b0;
        end
        if (w_accept && w_cls.legal && w_cls.writes_rd) begin
            w_pending_next[w_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // ----------------------------------------------------- output register
    decode_req_t w_req_next;

    always_comb begin
        w_req_next           = '0;
        w_req_next.opcode    = opcode_e'(w_op);
        w_req_next.rd        = w_rd;
        w_req_next.ra_data   = w_ra_data;
        w_req_next.rb_data   = w_rb_data;
        w_req_next.imm       = {{(REG_WIDTH-IMM_W){fetch_instr_data[IMM_W-1]}},
                                fetch_instr_data[IMM_W-1:0]};
        w_req_next.pc        = fetch_instr_pc;
        w_req_next.writes_rd = w_cls.writes_rd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_info  <= '0;
            r_xcpt      <= '0;
        end else if (flush_decode) begin
            r_req_valid  <= 1'b0;
            r_xcpt.valid <= 1'b0;
        end else if (!stall_decode) begin
            if (w_accept && w_cls.legal) begin
                r_req_valid  <= 1'b1;
                r_req_info   <= w_req_next;
                r_xcpt.valid <= 1'b0;
            end else if (w_accept) begin
                // Illegal opcode: report it, issue nothing.
                r_req_valid  <= 1'b0;
                r_xcpt.valid <= 1'b1;
                r_xcpt.cause <= ILLEGAL_INSTR;
                r_xcpt.pc    <= fetch_instr_pc;
            end else begin
                // Nothing offered, or a hazard: insert a bubble.
                r_req_valid  <= 1'b0;
                r_xcpt.valid <= 1'b0;
            end
        end
    end

    assign alu_req_valid = r_req_valid;
    assign alu_req_info  = r_req_info;
    assign xcpt_decode   = r_xcpt;

endmodule

// File: tb/tb_decode_top.sv
// -----------------------------------------------------------------------------
// tb_decode_top
// Directed bench for decode_top. A behavioural model (register values,
// pending set, expected output register) is advanced every clock edge from
// the instruction-set rules; every cycle the DUT outputs are compared with
// it, and hand-computed literal expectations pin the key scenarios.
// Honours DECODE_WB_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_decode_top;
    import decode_top_pkg::*;

    logic         clock;
    logic         reset;
    logic         fetch_instr_valid;
    logic [31:0]  fetch_instr_data;
    logic [31:0]  fetch_instr_pc;
    logic         stall_fetch;
    logic         stall_decode;
    logic         flush_decode;
    logic         wb_valid;
    logic [4:0]   wb_dest;
    logic [31:0]  wb_data;
    logic         alu_req_valid;
    decode_req_t  alu_req_info;
    decode_xcpt_t xcpt_decode;

    decode_top dut (
        .clock             (clock),
        .reset             (reset),
        .fetch_instr_valid (fetch_instr_valid),
        .fetch_instr_data  (fetch_instr_data),
        .fetch_instr_pc    (fetch_instr_pc),
        .stall_fetch       (stall_fetch),
        .stall_decode      (stall_decode),
        .flush_decode      (flush_decode),
        .wb_valid          (wb_valid),
        .wb_dest           (wb_dest),
        .wb_data           (wb_data),
        .alu_req_valid     (alu_req_valid),
        .alu_req_info      (alu_req_info),
        .xcpt_decode       (xcpt_decode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------ model
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          e_valid;
    logic [6:0]  e_op;
    logic [4:0]  e_rd;
    logic [31:0] e_ra, e_rb, e_imm, e_pc;
    bit          e_wr;
    bit          ex_valid;
    logic [31:0] ex_pc;

    function automatic bit legal_op(logic [6:0] op);
        return op inside {7'h00, 7'h01, 7'h02, 7'h03, 7'h11, 7'h13, 7'h30, 7'h31, 7'h7F};
    endfunction
    function automatic bit uses_a(logic [6:0] op);
        return op inside {7'h00, 7'h01, 7'h02, 7'h03, 7'h11, 7'h13, 7'h30, 7'h31};
    endfunction
    function automatic bit uses_b(logic [6:0] op);
        return op inside {7'h00, 7'h01, 7'h02, 7'h13, 7'h30};
    endfunction
    function automatic bit writes(logic [6:0] op, logic [4:0] rd);
        return (op inside {7'h00, 7'h01, 7'h02, 7'h03, 7'h11}) && (rd != 0);
    endfunction

    function automatic bit fwd(logic [4:0] r);
`ifdef DECODE_WB_BYPASS_EN
        return wb_valid && (wb_dest == r) && (r != 0);
`else
        return (r != r); // no same-cycle forwarding in this build
`endif
    endfunction

    function automatic bit busy(logic [4:0] r);
        return (r != 0) && m_pend[r] && !fwd(r);
    endfunction

    function automatic logic [31:0] src_val(logic [4:0] r);
        if (r == 0) return 32'd0;
        if (fwd(r)) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit model_hazard();
        logic [6:0] op;
        logic [4:0] rd, ra, rb;
        op = fetch_instr_data[31:25];
        rd = fetch_instr_data[24:20];
        ra = fetch_instr_data[19:15];
        rb = fetch_instr_data[14:10];
        return fetch_instr_valid &&
               ((uses_a(op) && busy(ra)) || (uses_b(op) && busy(rb)) ||
                (writes(op, rd) && m_pend[rd]));
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
            e_valid  = 1'b0;
            ex_valid = 1'b0;
        end else begin
            logic [6:0] op;
            logic [4:0] rd, ra, rb;
            bit haz, acc, rel;
            logic [4:0] rel_rd;
            op     = fetch_instr_data[31:25];
            rd     = fetch_instr_data[24:20];
            ra     = fetch_instr_data[19:15];
            rb     = fetch_instr_data[14:10];
            haz    = model_hazard();
            acc    = fetch_instr_valid && !haz && !stall_decode && !flush_decode;
            rel    = flush_decode && e_valid && e_wr;
            rel_rd = e_rd;
            if (flush_decode) begin
                e_valid  = 1'b0;
                ex_valid = 1'b0;
            end else if (!stall_decode) begin
                if (acc && legal_op(op)) begin
                    e_valid  = 1'b1;
                    ex_valid = 1'b0;
                    e_op     = op;
                    e_rd     = rd;
                    e_ra     = uses_a(op) ? src_val(ra) : 32'd0;
                    e_rb     = uses_b(op) ? src_val(rb) : 32'd0;
                    e_imm    = fetch_instr_data[14] ? (32'(fetch_instr_data[14:0]) - 32'd32768)
                                                    : 32'(fetch_instr_data[14:0]);
                    e_pc     = fetch_instr_pc;
                    e_wr     = writes(op, rd);
                end else if (acc) begin
                    e_valid  = 1'b0;
                    ex_valid = 1'b1;
                    ex_pc    = fetch_instr_pc;
                end else begin
                    e_valid  = 1'b0;
                    ex_valid = 1'b0;
                end
            end
            if (wb_valid && wb_dest != 0) begin
                m_regs[wb_dest] = wb_data;
                m_pend[wb_dest] = 1'b0;
            end
            if (rel) m_pend[rel_rd] = 1'b0;
            if (acc && legal_op(op) && writes(op, rd)) m_pend[rd] = 1'b1;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, made mid-cycle on the falling edge.
    task automatic compare_cycle();
        chk("cyc_stall_fetch", 32'(stall_fetch), 32'(stall_decode || model_hazard()));
        chk("cyc_alu_valid", 32'(alu_req_valid), 32'(e_valid));
        if (e_valid && alu_req_valid) begin
            chk("cyc_opcode", 32'(alu_req_info.opcode), 32'(e_op));
            chk("cyc_rd", 32'(alu_req_info.rd), 32'(e_rd));
            chk("cyc_ra_data", alu_req_info.ra_data, e_ra);
            chk("cyc_rb_data", alu_req_info.rb_data, e_rb);
            chk("cyc_imm", alu_req_info.imm, e_imm);
            chk("cyc_pc", alu_req_info.pc, e_pc);
            chk("cyc_writes_rd", 32'(alu_req_info.writes_rd), 32'(e_wr));
        end
        chk("cyc_xcpt_valid", 32'(xcpt_decode.valid), 32'(ex_valid));
        if (ex_valid && xcpt_decode.valid) begin
            chk("cyc_xcpt_cause", 32'(xcpt_decode.cause), 32'(ILLEGAL_INSTR));
            chk("cyc_xcpt_pc", xcpt_decode.pc, ex_pc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        compare_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [31:0] instr, input logic [31:0] pc);
        fetch_instr_valid = v;
        fetch_instr_data  = instr;
        fetch_instr_pc    = pc;
    endtask

    task automatic set_wb(input bit v, input logic [4:0] d, input logic [31:0] data);
        wb_valid = v;
        wb_dest  = d;
        wb_data  = data;
    endtask

    function automatic logic [31:0] enc_r(logic [6:0] op, logic [4:0] rd, logic [4:0] ra, logic [4:0] rb);
        return {op, rd, ra, rb, 10'd0};
    endfunction
    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [4:0] ra, logic [14:0] imm);
        return {op, rd, ra, imm};
    endfunction

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [31:0] tbl [5];
        reset        = 1'b1;
        stall_decode = 1'b0;
        flush_decode = 1'b0;
        set_in(0, 32'd0, 32'd0);
        set_wb(0, 5'd0, 32'd0);
        repeat (2) tick();

        // Reset state
        chk("rst_alu_valid", 32'(alu_req_valid), 32'd0);
        chk("rst_xcpt_valid", 32'(xcpt_decode.valid), 32'd0);
        chk("rst_info_zero", 32'(alu_req_info == '0), 32'd1);
        chk("rst_stall_fetch", 32'(stall_fetch), 32'd0);
        stall_decode = 1'b1;
        #1;
        chk("rst_stall_follows", 32'(stall_fetch), 32'd1);
        stall_decode = 1'b0;
        reset = 1'b0;
        tick();

        // Preload r1=5, r2=7
        set_wb(1, 5'd1, 32'd5); tick();
        set_wb(1, 5'd2, 32'd7); tick();
        set_wb(0, 5'd0, 32'd0);

        // ADD r3,r1,r2
        set_in(1, enc_r(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h100);
        #1 chk("add_no_stall", 32'(stall_fetch), 32'd0);
        tick();
        chk("add_valid", 32'(alu_req_valid), 32'd1);
        chk("add_ra", alu_req_info.ra_data, 32'd5);
        chk("add_rb", alu_req_info.rb_data, 32'd7);
        chk("add_rd", 32'(alu_req_info.rd), 32'd3);

        // SUB r4,r3,r1 back-to-back: RAW on r3
        set_in(1, enc_r(OP_SUB, 5'd4, 5'd3, 5'd1), 32'h104);
        #1 chk("raw_stall", 32'(stall_fetch), 32'd1);
        tick();
        chk("raw_bubble", 32'(alu_req_valid), 32'd0);
        set_wb(1, 5'd3, 32'd42);
        #1;
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_cycle_stall", 32'(stall_fetch), 32'd0);
        tick();
        set_wb(0, 5'd0, 32'd0);
`else
        chk("wb_cycle_stall", 32'(stall_fetch), 32'd1);
        tick();
        set_wb(0, 5'd0, 32'd0);
        chk("wb_cycle_bubble", 32'(alu_req_valid), 32'd0);
        #1 chk("after_wb_stall", 32'(stall_fetch), 32'd0);
        tick();
`endif
        chk("sub_valid", 32'(alu_req_valid), 32'd1);
        chk("sub_opcode", 32'(alu_req_info.opcode), 32'h01);
        chk("sub_ra", alu_req_info.ra_data, 32'd42);
        chk("sub_rb", alu_req_info.rb_data, 32'd5);
        set_in(0, 32'd0, 32'd0);
        set_wb(1, 5'd4, 32'd37);
        tick();
        set_wb(0, 5'd0, 32'd0);

        // Illegal opcode 0x55 at 0x1000
        set_in(1, {7'h55, 5'd9, 20'd0}, 32'h1000);
        tick();
        chk("ill_xcpt_valid", 32'(xcpt_decode.valid), 32'd1);
        chk("ill_xcpt_cause", 32'(xcpt_decode.cause), 32'(ILLEGAL_INSTR));
        chk("ill_xcpt_pc", xcpt_decode.pc, 32'h1000);
        chk("ill_alu_valid", 32'(alu_req_valid), 32'd0);
        set_in(1, enc_r(OP_ADD, 5'd10, 5'd9, 5'd0), 32'h1004);
        #1 chk("ill_no_pending", 32'(stall_fetch), 32'd0);
        tick();
        chk("after_ill_valid", 32'(alu_req_valid), 32'd1);
        chk("after_ill_xcpt", 32'(xcpt_decode.valid), 32'd0);

        // ADDI r5,r1,-3 then hold with stall_decode, then flush
        set_in(1, enc_i(OP_ADDI, 5'd5, 5'd1, 15'h7FFD), 32'h200);
        set_wb(1, 5'd10, 32'd1);
        tick();
        set_wb(0, 5'd0, 32'd0);
        chk("addi_imm", alu_req_info.imm, 32'hFFFF_FFFD);
        chk("addi_ra", alu_req_info.ra_data, 32'd5);
        chk("addi_wr", 32'(alu_req_info.writes_rd), 32'd1);
        stall_decode = 1'b1;
        set_in(1, {7'h7F, 25'd0}, 32'h204);
        #1 chk("sd_stall_fetch", 32'(stall_fetch), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(alu_req_valid), 32'd1);
            chk("hold_pc", alu_req_info.pc, 32'h200);
            chk("hold_imm", alu_req_info.imm, 32'hFFFF_FFFD);
        end
        flush_decode = 1'b1;
        tick();
        flush_decode = 1'b0;
        stall_decode = 1'b0;
        chk("flush_valid", 32'(alu_req_valid), 32'd0);
        set_in(1, enc_r(OP_ADD, 5'd7, 5'd5, 5'd0), 32'h300);
        #1 chk("flush_released_r5", 32'(stall_fetch), 32'd0);
        tick();
        chk("r5_reader_valid", 32'(alu_req_valid), 32'd1);
        chk("r5_reader_rd", 32'(alu_req_info.rd), 32'd7);

        // r0 as destination and as sources
        set_in(1, enc_r(OP_ADD, 5'd0, 5'd1, 5'd2), 32'h400);
        #1 chk("r0_dst_no_stall", 32'(stall_fetch), 32'd0);
        tick();
        chk("r0_dst_no_write", 32'(alu_req_info.writes_rd), 32'd0);
        set_in(1, enc_r(OP_ADD, 5'd6, 5'd0, 5'd0), 32'h404);
        #1 chk("r0_src_no_stall", 32'(stall_fetch), 32'd0);
        tick();
        chk("r0_ra_zero", alu_req_info.ra_data, 32'd0);
        chk("r0_rb_zero", alu_req_info.rb_data, 32'd0);
        chk("r0_rd6", 32'(alu_req_info.rd), 32'd6);

        // WAW on r6: held through its own writeback cycle
        set_in(1, enc_i(OP_ADDI, 5'd6, 5'd1, 15'd1), 32'h408);
        #1 chk("waw_stall", 32'(stall_fetch), 32'd1);
        tick();
        chk("waw_bubble", 32'(alu_req_valid), 32'd0);
        set_wb(1, 5'd6, 32'd11);
        #1 chk("waw_wb_cycle", 32'(stall_fetch), 32'd1);
        tick();
        set_wb(0, 5'd0, 32'd0);
        #1 chk("waw_released", 32'(stall_fetch), 32'd0);
        tick();
        chk("waw_issue_pc", alu_req_info.pc, 32'h408);
        chk("waw_issue_imm", alu_req_info.imm, 32'd1);

        // Set beats a same-cycle writeback clear on r11
        set_in(1, enc_r(OP_ADD, 5'd11, 5'd1, 5'd1), 32'h500);
        set_wb(1, 5'd11, 32'd99);
        tick();
        set_wb(0, 5'd0, 32'd0);
        set_in(1, enc_r(OP_SUB, 5'd12, 5'd11, 5'd0), 32'h504);
        #1 chk("set_wins", 32'(stall_fetch), 32'd1);
        tick();
        set_wb(1, 5'd11, 32'd3);
        tick();
        set_wb(0, 5'd0, 32'd0);
        tick();
        set_in(0, 32'd0, 32'd0);
        tick();

        // Remaining opcodes, model-checked
        tbl[0] = enc_r(OP_STW, 5'd0, 5'd1, 5'd2);
        tbl[1] = enc_i(OP_BEQ, 5'd0, 5'd1, 15'h4802);
        tbl[2] = enc_r(OP_JUMP, 5'd0, 5'd2, 5'd0);
        tbl[3] = enc_i(OP_LDW, 5'd13, 5'd1, 15'h0010);
        tbl[4] = enc_r(OP_MUL, 5'd14, 5'd1, 5'd2);
        for (int i = 0; i < 5; i++) begin
            set_in(1, tbl[i], 32'h700 + 32'(4 * i));
            tick();
        end

        // Reset asserted mid-stall discards the held request
        set_in(1, enc_r(OP_ADD, 5'd15, 5'd1, 5'd2), 32'h600);
        tick();
        stall_decode = 1'b1;
        set_in(0, 32'd0, 32'd0);
        tick();
        chk("pre_rst_valid", 32'(alu_req_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(alu_req_valid), 32'd0);
        chk("rst_mid_stall", 32'(stall_fetch), 32'd1);
        tick();
        stall_decode = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_rst_valid", 32'(alu_req_valid), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
